// File: rtl/tank_dec_f1.sv
// F1 tank decoder: accepts a store-access request, waits for the addressed minor
// cycle to come round, then drives the down/up x in/out decoder gates for one minor cycle.
module tank_dec_f1 #(
    parameter int DIGITS_PER_MINOR = 36,
    parameter int MINORS_PER_MAJOR = 16,
    parameter int TANK_GROUP       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_pulse,
    input  logic       minor_sync,
    input  logic       major_sync,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_long,
    input  logic       req_half,
    input  logic [4:0] req_tank,
    input  logic [3:0] req_pos,
    input  logic       abort,
    output logic       f1_down_dec_in,
    output logic       f1_down_dec_out,
    output logic       f1_up_dec_in,
    output logic       f1_up_dec_out,
    output logic       f7_pos,
    output logic       f8_pos,
    output logic       done,
    output logic       hit
);

    localparam int DW = $clog2(DIGITS_PER_MINOR);
    localparam int MW = $clog2(MINORS_PER_MAJOR);
    localparam logic [DW-1:0] DIGIT_MAX = DW'(DIGITS_PER_MINOR - 1);
    localparam logic [DW-1:0] LAST_DOWN = DW'(DIGITS_PER_MINOR / 2 - 1);
    localparam logic [MW-1:0] MINOR_MAX = MW'(MINORS_PER_MAJOR - 1);
    localparam logic [2:0]    GROUP     = 3'(TANK_GROUP);

    typedef enum logic [1:0] {IDLE, WAIT, GATE, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] digit_cnt_q, digit_cnt_d;
    logic [MW-1:0] minor_cnt_q, minor_cnt_d;
    logic          hit_q, hit_d;
    logic          write_q, long_q, half_q;
    logic [MW-1:0] pos_q;
    logic          f7_q, f8_q;
    logic [3:0]    gate_q, gate_d;   // {down_in, down_out, up_in, up_out}
    logic          accept, coincide;

    assign accept   = req_valid && (state_q == IDLE);
    assign coincide = minor_sync && (minor_cnt_d == pos_q);

    always_comb begin
        minor_cnt_d = minor_cnt_q;
        if (major_sync)
            minor_cnt_d = '0;
        else if (minor_sync)
            minor_cnt_d = (minor_cnt_q == MINOR_MAX) ? '0 : minor_cnt_q + 1'b1;
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            digit_cnt_q <= '0;
            minor_cnt_q <= '0;
            hit_q       <= 1'b0;
            write_q     <= 1'b0;
            long_q      <= 1'b0;
            half_q      <= 1'b0;
            pos_q       <= '0;
            f7_q        <= 1'b0;
            f8_q        <= 1'b0;
            gate_q      <= '0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            minor_cnt_q <= minor_cnt_d;
            hit_q       <= hit_d;
            gate_q      <= gate_d;
            if (accept) begin
                write_q <= req_write;
                long_q  <= req_long;
                half_q  <= req_half;
                pos_q   <= req_pos;
                f7_q    <= req_tank[0];
                f8_q    <= req_tank[1];
            end
        end
    end

    // NOTE: every variable gets a default at the top of the comb block so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        hit_d       = hit_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hit_d   = 1'b0;
                    state_d = (req_tank[4:2] == GROUP) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = DONE;
                end else if (coincide) begin
                    state_d     = GATE;
                    digit_cnt_d = '0;
                end
            end
            GATE: begin
                if (abort) begin
                    state_d = DONE;
                end else if (minor_sync) begin
                    state_d = DONE;
                    hit_d   = 1'b1;
                end else if (digit_pulse && (digit_cnt_q != DIGIT_MAX)) begin
                    digit_cnt_d = digit_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gates are decoded from next state so they change on the same edge as the FSM.
    always_comb begin
        logic in_gate, down_sel, up_sel;
        in_gate  = (state_d == GATE);
        down_sel = in_gate && (digit_cnt_d <= LAST_DOWN) && (long_q || !half_q);
        up_sel   = in_gate && (digit_cnt_d >  LAST_DOWN) && (long_q ||  half_q);
        gate_d   = {down_sel && write_q, down_sel && !write_q,
                    up_sel && write_q,   up_sel && !write_q};
        req_ready = (state_q == IDLE);
        done      = (state_q == DONE);
        hit       = (state_q == DONE) && hit_q;
    end

    assign {f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out} = gate_q;
    assign f7_pos = f7_q;
    assign f8_pos = f8_q;

endmodule

// File: tb/tb_tank_dec_f1.sv
// Directed bench for tank_dec_f1: one digit_pulse per clk, bench-owned minor/major timebase.
module tb_tank_dec_f1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_pulse, minor_sync, major_sync;
    logic       req_valid, req_ready, req_write, req_long, req_half;
    logic [4:0] req_tank;
    logic [3:0] req_pos;
    logic       abort;
    logic       f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out;
    logic       f7_pos, f8_pos, done, hit;

    int n_checks = 0;
    int n_fail   = 0;
    int ph = 0;   // digit slot of the current cycle, 0 = minor_sync cycle
    int mn = 0;   // minor index that minor_sync in this minor cycle announces

    // watch() results
    int c_din, c_dout, c_uin, c_uout, multi;
    int first_k, first_mn, first_ph, first_up_ph;
    int done_k, done_mn, done_ph, done_hit;

    tank_dec_f1 dut (
        .clk(clk), .rst_n(rst_n),
        .digit_pulse(digit_pulse), .minor_sync(minor_sync), .major_sync(major_sync),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_long(req_long), .req_half(req_half), .req_tank(req_tank), .req_pos(req_pos),
        .abort(abort),
        .f1_down_dec_in(f1_down_dec_in), .f1_down_dec_out(f1_down_dec_out),
        .f1_up_dec_in(f1_up_dec_in), .f1_up_dec_out(f1_up_dec_out),
        .f7_pos(f7_pos), .f8_pos(f8_pos), .done(done), .hit(hit)
    );

    always #5 clk = ~clk;

    assign digit_pulse = 1'b1;
    assign minor_sync  = (ph == 0);
    assign major_sync  = (ph == 0) && (mn == 0);

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ph == 35) begin
                ph = 0;
                mn = (mn + 1) % 16;
            end else begin
                ph = ph + 1;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_slot(input int m, input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mn == m && ph == p) && n < 1200);
        check("slot_reached", (mn == m && ph == p) ? 1 : 0, 1);
    endtask

    task automatic issue(input logic [4:0] tank, input logic [3:0] pos,
                         input logic lng, input logic half, input logic wr);
        check("ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_tank  = tank;
        req_pos   = pos;
        req_long  = lng;
        req_half  = half;
        req_write = wr;
    endtask

    task automatic watch(input int budget, input int ab_mn, input int ab_ph);
        c_din = 0; c_dout = 0; c_uin = 0; c_uout = 0; multi = 0;
        first_k = -1; first_mn = -1; first_ph = -1; first_up_ph = -1;
        done_k = -1; done_mn = -1; done_ph = -1; done_hit = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            abort     = 1'b0;
            c_din  += int'(f1_down_dec_in);
            c_dout += int'(f1_down_dec_out);
            c_uin  += int'(f1_up_dec_in);
            c_uout += int'(f1_up_dec_out);
            if ($countones({f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out}) > 1)
                multi++;
            if ((f1_down_dec_in | f1_down_dec_out | f1_up_dec_in | f1_up_dec_out) && first_k < 0) begin
                first_k = k; first_mn = mn; first_ph = ph;
            end
            if ((f1_up_dec_in | f1_up_dec_out) && first_up_ph < 0)
                first_up_ph = ph;
            if (done) begin
                done_k = k; done_mn = mn; done_ph = ph; done_hit = int'(hit);
                break;
            end
            if (mn == ab_mn && ph == ab_ph)
                abort = 1'b1;
        end
        req_valid = 1'b0;
        abort     = 1'b0;
        check("done_seen", (done_k >= 0) ? 1 : 0, 1);
        check("one_gate_max", multi, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_long = 1'b0;
        req_half = 1'b0; req_tank = '0; req_pos = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_gates", {f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out}, 0);
        check("rst_f7f8", {f8_pos, f7_pos}, 0);
        rst_n = 1'b1;

        // Long read, tank 3, pos 7
        wait_slot(5, 10);
        issue(5'b00011, 4'd7, 1'b1, 1'b0, 1'b0);
        watch(2000, -1, -1);
        check("lr_f7", f7_pos, 1);
        check("lr_f8", f8_pos, 1);
        check("lr_first_minor", first_mn, 7);
        check("lr_first_ph", first_ph, 1);
        check("lr_down_out", c_dout, 18);
        check("lr_up_out", c_uout, 18);
        check("lr_in_gates", c_din + c_uin, 0);
        check("lr_up_start", first_up_ph, 19);
        check("lr_done_minor", done_mn, 8);
        check("lr_done_ph", done_ph, 1);
        check("lr_hit", done_hit, 1);

        // Short write, up half, pos 0
        wait_slot(10, 3);
        issue(5'b00010, 4'd0, 1'b0, 1'b1, 1'b1);
        watch(2000, -1, -1);
        check("sw_f7f8", {f8_pos, f7_pos}, 2);
        check("sw_up_in", c_uin, 18);
        check("sw_other", c_din + c_dout + c_uout, 0);
        check("sw_first_minor", first_mn, 0);
        check("sw_first_ph", first_ph, 19);
        check("sw_done_minor", done_mn, 1);
        check("sw_hit", done_hit, 1);

        // Group miss
        wait_slot(4, 4);
        issue(5'b01000, 4'd4, 1'b1, 1'b0, 1'b0);
        watch(100, -1, -1);
        check("miss_done_k", done_k, 0);
        check("miss_hit", done_hit, 0);
        check("miss_gates", c_din + c_dout + c_uin + c_uout, 0);
        check("miss_f7f8", {f8_pos, f7_pos}, 0);

        // Abort at digit 10 of a long write, pos 2
        wait_slot(0, 20);
        issue(5'b00001, 4'd2, 1'b1, 1'b0, 1'b1);
        watch(2000, 2, 11);
        check("ab_down_in", c_din, 11);
        check("ab_up", c_uin + c_uout, 0);
        check("ab_done_ph", done_ph, 12);
        check("ab_hit", done_hit, 0);
        @(negedge clk);
        check("ab_ready_after", req_ready, 1);
        check("ab_late_gate", {f1_down_dec_in, f1_up_dec_in}, 0);

        // Wrap: pos 15 accepted in minor 14
        wait_slot(14, 5);
        issue(5'b00000, 4'd15, 1'b1, 1'b0, 1'b0);
        watch(2000, -1, -1);
        check("wr_first_minor", first_mn, 15);
        check("wr_down_out", c_dout, 18);
        check("wr_up_out", c_uout, 18);
        check("wr_done_minor", done_mn, 0);
        check("wr_done_ph", done_ph, 1);
        check("wr_hit", done_hit, 1);

        // Accept on the matching minor_sync: gate one major cycle later
        wait_slot(3, 0);
        issue(5'b00000, 4'd3, 1'b0, 1'b0, 1'b0);
        watch(1500, -1, -1);
        check("late_first_k", first_k, 576);
        check("late_first_minor", first_mn, 3);
        check("late_down_out", c_dout, 18);
        check("late_up", c_uin + c_uout + c_din, 0);
        check("late_hit", done_hit, 1);

        // Reset in the middle of a gate
        wait_slot(6, 0);
        issue(5'b00011, 4'd8, 1'b1, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end while (!f1_down_dec_out && n < 1200);
        check("mid_gate_reached", f1_down_dec_out, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_gates", {f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out}, 0);
        check("mr_done", done, 0);
        check("mr_ready", req_ready, 1);
        check("mr_f7f8", {f8_pos, f7_pos}, 0);
        repeat (2) @(negedge clk);
        check("mr_gates_held", {f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out}, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mr_idle_after", req_ready, 1);
        check("mr_no_gate_after", {f1_down_dec_in, f1_down_dec_out, f1_up_dec_in, f1_up_dec_out}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tank_dec_f1.md
Name: tank_dec_f1

Overview:
- Upstream stage of the F1 tank distributor in the EDSAC control section.
- Accepts a store-access request (tank, minor-cycle position, short/long, half, read/write) from the order/control logic.
- Waits for the addressed word to come round in the delay line, then produces the four decoder gate strobes: down/up × in/out, gated digit by digit.
- Also drives the tank-select bits f7_pos/f8_pos that the distributor consumes.

Parameters:
- DIGITS_PER_MINOR, 36, digit periods per minor cycle; 0..17 are the down half, 18..35 the up half.
- MINORS_PER_MAJOR, 16, minor cycles per major cycle, which is the number of long-word positions in a tank.
- TANK_GROUP, 0, value of req_tank[4:2] that this F1 decoder serves.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- digit_pulse  in  1  one-clk strobe per digit period.
- minor_sync  in  1  one-clk strobe marking digit 0 of each minor cycle; always coincides with a digit_pulse.
- major_sync  in  1  one-clk strobe marking minor cycle 0; always coincides with minor_sync.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store write (in), 0 = read (out).
- req_long  in  1  1 = long word (both halves).
- req_half  in  1  short-word half select: 0 = down, 1 = up.
- req_tank  in  5  tank number.
- req_pos  in  4  minor-cycle position within the tank.
- abort  in  1  cancel the request in progress.
- f1_down_dec_in  out  1  down-half write gate.
- f1_down_dec_out  out  1  down-half read gate.
- f1_up_dec_in  out  1  up-half write gate.
- f1_up_dec_out  out  1  up-half read gate.
- f7_pos  out  1  latched req_tank[0].
- f8_pos  out  1  latched req_tank[1].
- done  out  1  one-clk completion pulse.
- hit  out  1  valid with done: 1 = tank in TANK_GROUP and transfer performed.

Behaviour:
- Reset (rst_n = 0 at a clk edge): every output is 0 except req_ready = 1. State becomes IDLE; minor_cnt = 0, digit_cnt = 0. Reset mid-transfer behaves the same way, with gates dropped on the next edge.
- minor_cnt is a free-running 4-bit counter. It is set to 0 on major_sync; otherwise, on minor_sync it becomes (minor_cnt + 1) mod MINORS_PER_MAJOR.
- req_ready = 1 only in IDLE. A request is accepted on a clk edge with req_valid & req_ready.
- On acceptance, latch all request fields and set f7_pos/f8_pos from the tank. f7_pos/f8_pos hold until the next acceptance or reset.
- IDLE, accept, tank[4:2] ≠ TANK_GROUP → state DONE; hit = 0; no gate is ever asserted.
- IDLE, accept, group match → state WAIT.
- WAIT: on a cycle where minor_sync is asserted and the new minor index equals the latched pos, go to GATE with digit_cnt = 0. The new index is 0 if major_sync, else minor_cnt + 1.
  - An accept on the very cycle of a matching minor_sync does not coincide until the next major cycle.
- GATE: gates are registered and asserted from the clk after the coincidence edge.
  - digit_cnt increments on each digit_pulse and saturates at 35.
  - Down gate is high while digit_cnt ≤ 17; up gate is high while digit_cnt ≥ 18. The switch happens on the edge of the digit_pulse that ends digit 17.
  - Long: down gate, then up gate. Short with half = 0: down gate only. Short with half = 1: up gate only.
  - The _in gate is used when write = 1, the _out gate when write = 0. In and out gates are never both high.
  - GATE lasts exactly one minor cycle. At the next minor_sync, all gates drop on that edge and the state goes to DONE.
- DONE: done = 1 for one clk; hit = 1 if a transfer occurred. Then IDLE, with req_ready = 1 on the following cycle.
- abort in WAIT or GATE: gates drop on the next edge; state goes to DONE with hit = 0. abort in IDLE or DONE is ignored.
- Simultaneous abort and coincidence: abort wins.
- At most one gate output is high in any cycle.

Test Plan:
- Reset: hold rst_n = 0 for 3 clk during GATE → all gates 0, done = 0, req_ready = 1 after the edge; f7_pos = f8_pos = 0.
- Long read: tank 5'b00011, pos 7, long. → f7_pos = f8_pos = 1. f1_down_dec_out high for digits 0–17 of minor 7, then f1_up_dec_out for 18–35, then done = 1, hit = 1 one clk after minor_sync of minor 8.
- Short write up: pos 0, half = 1, write. → only f1_up_dec_in asserts, for digits 18–35 of minor 0; no down gate at any time.
- Group miss: tank 5'b01000. → no gates; done = 1, hit = 0 on the second clk after accept.
- Abort: abort at digit 10 of a long write. → f1_down_dec_in falls next edge, done = 1 with hit = 0, up gate never asserts.
- Wrap: accept pos 15 while minor_cnt = 14, then major_sync. → gate in minor 15, done in the cycle after major_sync. Accept pos 3 on the minor_sync entering minor 3 → gate a full major cycle (16 minors) later.
